pic_cmd_sequencer: RTL and testbench
====================================

Name: pic_cmd_sequencer

Overview:
Clocked, parametrised successor to the PIC read/write command logic.
- Synchronises the CPU strobes WR_n/RD_n into the core clock domain.
- Sequences ICW1..ICW4 with an explicit FSM, then decodes OCW1..OCW3.
- Replaces the level change/ACK flag pairs with single-cycle strobes.
- Adds re-initialisation at any time, an init timeout, and read-select tracking.
- Sits between the data bus buffer and the control logic / IRR/ISR/IMR blocks.

Parameters:
DATA_W, 8, width of the command/data bus; must be >= 8 (field decode uses bits 4:0).
SYNC_STAGES, 2, synchroniser flops on wr_n and rd_n; legal range 2..4.
INIT_TIMEOUT, 0, clk cycles allowed between consecutive ICWs; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cs_n  in  1  chip select, active low
wr_n  in  1  CPU write strobe, active low, asynchronous to clk
rd_n  in  1  CPU read strobe, active low, asynchronous to clk
a0  in  1  address bit 0
din  in  DATA_W  internal data bus from the buffer
icw1, icw2, icw3, icw4  out  DATA_W each  latched initialisation words
ocw1, ocw2, ocw3  out  DATA_W each  latched operation words (ocw1 = IMR)
init_done  out  1  high in READY
icw_state  out  3  FSM encoding: IDLE=0, W2=1, W3=2, W4=3, READY=4
ocw1_wr, ocw2_wr, ocw3_wr  out  1 each  one-cycle strobe on OCW commit
icw1_wr  out  1  one-cycle strobe on ICW1 commit
init_error  out  1  one-cycle strobe on init timeout or illegal write during init
rd_en  out  1  level; buffer drives the CPU bus
rd_strobe  out  1  one-cycle strobe at read start
rd_sel  out  2  source select: 00 IRR, 01 ISR, 10 IMR

Behaviour:
Reset (async, rst_n low):
- All icw*/ocw* = 0; state IDLE; init_done = 0.
- All strobes = 0; rd_en = 0; rd_sel = 00.
- Synchroniser flops preset to 1.

Write capture:
- Each clk where synced wr_n = 0 and cs_n = 0, register a0 and din into a capture buffer and set a valid bit.
- A write commits in the cycle after the synced wr_n rising edge is detected, only if the valid bit is set; the valid bit then clears.
- cs_n high for the whole pulse: write dropped, no strobe.
- Latency: strobe or register update appears 1 clk after the synced rising edge, SYNC_STAGES+1 clk after the pin edge.

Decode of a committed write (priority order):
- a0=0 and d[4]=1 is ICW1, accepted in any state:
  - icw1 <= d; icw2, icw3, icw4, ocw1 <= 0; rd_sel <= 00; icw1_wr pulses; state -> W2.
- W2, a0=1:
  - icw2 <= d.
  - Next state is W3 if d1 of icw1 (SNGL) = 0.
  - Otherwise W4 if d0 of icw1 (IC4) = 1.
  - Otherwise READY.
- W3, a0=1: icw3 <= d; state -> W4 if IC4=1, else READY.
- W4, a0=1: icw4 <= d; state -> READY.
- W2/W3/W4, a0=0 and d[4]=0: ignored; init_error pulses; state unchanged.
- IDLE: any non-ICW1 write is ignored silently.
- READY:
  - a0=1: ocw1 <= d; ocw1_wr pulses.
  - a0=0, d[4:3]=00: ocw2 <= d; ocw2_wr pulses.
  - a0=0, d[4:3]=01: ocw3 <= d; ocw3_wr pulses. If d[1] (RR) = 1, rd_sel <= {1'b0, d[0]}; if RR = 0, rd_sel holds.

Timeout:
- Counter clears on entry to W2/W3/W4 and on every committed ICW.
- If the count reaches INIT_TIMEOUT in W2/W3/W4: state -> IDLE, init_error pulses, icw regs hold their values.

Read:
- rd_en = synced rd_n = 0 and cs_n = 0 and synced wr_n = 1.
- rd_strobe pulses on the rd_en rising edge.
- While rd_en = 1: a0=1 forces rd_sel = 10; a0=0 restores the OCW3-selected value.
- Read and write overlapping: write wins; rd_en is forced 0 and no rd_strobe is issued.

Reset mid-operation: all state is lost immediately; the next access must be ICW1.

Optional Feature:
PIC_POLL_CMD_EN:
- Defined:
  - An OCW3 commit with d[2]=1 (P) sets poll_pending and pulses an extra output poll_req.
  - While poll_pending is set, rd_sel = 11 (poll word) regardless of a0; poll_pending clears on the next rd_strobe.
  - An OCW3 with both P=1 and RR=1 still updates rd_sel for later reads.
- Undefined: P is latched into ocw3 only; poll_req does not exist; rd_sel never takes the value 11.

Test Plan:
- Reset, then ICW1=0x13, ICW2=0x20, ICW4=0x01 (a0=0,1,1) -> state 0->1->3->4; init_done=1; icw3=0; icw1_wr exactly once.
- ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x1D -> passes through W3; icw3=0x04; then OCW1 0xFB -> ocw1=0xFB, ocw1_wr single pulse.
- In READY: OCW3 0x0B -> rd_sel=01; read a0=0 -> rd_en=1, rd_strobe=1 once, rd_sel=01; read a0=1 -> rd_sel=10; OCW3 0x08 (RR=0) -> rd_sel stays 01.
- INIT_TIMEOUT=16: ICW1=0x11, then no write for 20 clk -> init_error pulse at count 16; state=IDLE; a following a0=1 write is ignored.
- In READY with ocw1=0xFF: write ICW1=0x17 -> ocw1=0, state=W2, init_done=0; an a0=0 write 0x20 in W2 -> init_error pulses, ocw2 unchanged.
- cs_n=1 for a whole write pulse -> no register change, no strobe; wr_n and rd_n overlapping low -> rd_en stays 0, write commits normally.

Source files
------------

// File: rtl/pic_cmd_if.sv
// rtl/pic_cmd_if.sv - CPU-side command bus between the data bus buffer and the sequencer
interface pic_cmd_if #(
    parameter int DATA_W = 8
);
    logic              cs_n;
    logic              wr_n;
    logic              rd_n;
    logic              a0;
    logic [DATA_W-1:0] din;

    modport master (output cs_n, wr_n, rd_n, a0, din);
    modport slave  (input  cs_n, wr_n, rd_n, a0, din);
endinterface

// File: rtl/pic_cmd_sequencer.sv
// rtl/pic_cmd_sequencer.sv - PIC ICW/OCW command sequencer; PIC_POLL_CMD_EN adds the poll command
module pic_cmd_sequencer #(
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int INIT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    pic_cmd_if.slave          bus,
    output logic [DATA_W-1:0] icw1,
    output logic [DATA_W-1:0] icw2,
    output logic [DATA_W-1:0] icw3,
    output logic [DATA_W-1:0] icw4,
    output logic [DATA_W-1:0] ocw1,
    output logic [DATA_W-1:0] ocw2,
    output logic [DATA_W-1:0] ocw3,
    output logic              init_done,
    output logic [2:0]        icw_state,
    output logic              ocw1_wr,
    output logic              ocw2_wr,
    output logic              ocw3_wr,
    output logic              icw1_wr,
    output logic              init_error,
    output logic              rd_en,
    output logic              rd_strobe,
`ifdef PIC_POLL_CMD_EN
    output logic              poll_req,
`endif
    output logic [1:0]        rd_sel
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W2    = 3'd1,
        S_W3    = 3'd2,
        S_W4    = 3'd3,
        S_READY = 3'd4
    } state_t;

    localparam int CNT_W = (INIT_TIMEOUT > 0) ? $clog2(INIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INIT_TIMEOUT);

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
    logic                wr_s, rd_s, wr_prev, wr_rise, commit;
    logic                cap_valid, cap_a0;
    logic [DATA_W-1:0]   cap_d;
    logic [CNT_W-1:0]    cnt;
    logic                in_w, tmo, rd_en_q;
    logic [1:0]          rd_sel_q;
    logic ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_ocw1, ld_ocw2, ld_ocw3, err_d;

    assign wr_s    = wr_sync[SYNC_STAGES-1];
    assign rd_s    = rd_sync[SYNC_STAGES-1];
    assign wr_rise = wr_s & ~wr_prev;
    assign commit  = wr_rise & cap_valid;
    assign in_w    = (state_q == S_W2) || (state_q == S_W3) || (state_q == S_W4);
    assign tmo     = (INIT_TIMEOUT != 0) && in_w && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync   <= '1;
            rd_sync   <= '1;
            wr_prev   <= 1'b1;
            rd_en_q   <= 1'b0;
            cap_valid <= 1'b0;
            cap_a0    <= 1'b0;
            cap_d     <= '0;
        end else begin
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.wr_n};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus.rd_n};
            wr_prev <= wr_s;
            rd_en_q <= rd_en;
            // Capture keeps refreshing while the strobe is low so the last bus value wins
            if (!wr_s && !bus.cs_n) begin
                cap_valid <= 1'b1;
                cap_a0    <= bus.a0;
                cap_d     <= bus.din;
            end else if (wr_rise) begin
                cap_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ld_icw1 = 1'b0; ld_icw2 = 1'b0; ld_icw3 = 1'b0; ld_icw4 = 1'b0;
        ld_ocw1 = 1'b0; ld_ocw2 = 1'b0; ld_ocw3 = 1'b0;
        err_d   = 1'b0;
        if (commit) begin
            if (!cap_a0 && cap_d[4]) begin
                ld_icw1 = 1'b1;
                state_d = S_W2;
            end else begin
                case (state_q)
                    S_W2: if (cap_a0) begin
                        ld_icw2 = 1'b1;
                        state_d = !icw1[1] ? S_W3 : (icw1[0] ? S_W4 : S_READY);
                    end else err_d = 1'b1;
                    S_W3: if (cap_a0) begin
                        ld_icw3 = 1'b1;
                        state_d = icw1[0] ? S_W4 : S_READY;
                    end else err_d = 1'b1;
                    S_W4: if (cap_a0) begin
                        ld_icw4 = 1'b1;
                        state_d = S_READY;
                    end else err_d = 1'b1;
                    S_READY: begin
                        if (cap_a0)        ld_ocw1 = 1'b1;
                        else if (!cap_d[3]) ld_ocw2 = 1'b1;
                        else               ld_ocw3 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (tmo) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            icw1 <= '0; icw2 <= '0; icw3 <= '0; icw4 <= '0;
            ocw1 <= '0; ocw2 <= '0; ocw3 <= '0;
            rd_sel_q <= 2'b00;
            cnt      <= '0;
            icw1_wr <= 1'b0; ocw1_wr <= 1'b0; ocw2_wr <= 1'b0; ocw3_wr <= 1'b0;
            init_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            icw1_wr    <= ld_icw1;
            ocw1_wr    <= ld_ocw1;
            ocw2_wr    <= ld_ocw2;
            ocw3_wr    <= ld_ocw3;
            init_error <= err_d;
            if (ld_icw1) begin
                icw1 <= cap_d;
                icw2 <= '0; icw3 <= '0; icw4 <= '0; ocw1 <= '0;
                rd_sel_q <= 2'b00;
            end
            if (ld_icw2) icw2 <= cap_d;
            if (ld_icw3) icw3 <= cap_d;
            if (ld_icw4) icw4 <= cap_d;
            if (ld_ocw1) ocw1 <= cap_d;
            if (ld_ocw2) ocw2 <= cap_d;
            if (ld_ocw3) begin
                ocw3 <= cap_d;
                if (cap_d[1]) rd_sel_q <= {1'b0, cap_d[0]};
            end
            if (ld_icw1 || ld_icw2 || ld_icw3 || ld_icw4) cnt <= '0;
            else if (in_w && cnt != CNT_MAX)          cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef PIC_POLL_CMD_EN
    logic poll_pending;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_pending <= 1'b0;
            poll_req     <= 1'b0;
        end else begin
            poll_req <= ld_ocw3 && cap_d[2];
            if (ld_ocw3 && cap_d[2]) poll_pending <= 1'b1;
            else if (rd_strobe)      poll_pending <= 1'b0;
        end
    end
`endif

    // A write in flight always wins over a read on the shared bus
    assign rd_en     = !rd_s && !bus.cs_n && wr_s;
    assign rd_strobe = rd_en && !rd_en_q;
    assign init_done = (state_q == S_READY);
    assign icw_state = state_q;

    always_comb begin
        rd_sel = rd_sel_q;
        if (rd_en && bus.a0) rd_sel = 2'b10;
`ifdef PIC_POLL_CMD_EN
        if (poll_pending) rd_sel = 2'b11;
`endif
    end
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb/tb_pic_cmd_sequencer.sv - randomized self-checking bench for pic_cmd_sequencer
module tb_pic_cmd_sequencer;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pic_cmd_if #(.DATA_W(DW)) bus ();

    logic [DW-1:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic          init_done, ocw1_wr, ocw2_wr, ocw3_wr, icw1_wr, init_error, rd_en, rd_strobe;
    logic [2:0]    icw_state;
    logic [1:0]    rd_sel;

    pic_cmd_sequencer #(.DATA_W(DW), .SYNC_STAGES(2), .INIT_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .ocw1(ocw1), .ocw2(ocw2), .ocw3(ocw3),
        .init_done(init_done), .icw_state(icw_state),
        .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr), .icw1_wr(icw1_wr),
        .init_error(init_error), .rd_en(rd_en), .rd_strobe(rd_strobe), .rd_sel(rd_sel)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cyc_icw1 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the init sequence is a list of ICW numbers still expected
    logic [7:0] m_icw [1:4];
    logic [7:0] m_ocw [1:3];
    logic [1:0] m_rd_sel;
    bit         m_ready;
    int         pend[$];

    function automatic int m_state();
        if (pend.size() > 0) return pend[0] - 1;
        return m_ready ? 4 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 4; i++) m_icw[i] = 8'h00;
        for (int i = 1; i <= 3; i++) m_ocw[i] = 8'h00;
        m_rd_sel = 2'b00;
        m_ready  = 1'b0;
        pend.delete();
    endtask

    task automatic model_timeout();
        pend.delete();
        m_ready = 1'b0;
    endtask

    // s: 0 none, 1 icw1_wr, 2 ocw1_wr, 3 ocw2_wr, 4 ocw3_wr, 5 init_error, 6 icw2..4 load
    task automatic model_write(input bit a, input logic [7:0] d, output int s);
        s = 0;
        if (!a && d[4]) begin
            m_icw[1] = d; m_icw[2] = 8'h00; m_icw[3] = 8'h00; m_icw[4] = 8'h00;
            m_ocw[1] = 8'h00; m_rd_sel = 2'b00; m_ready = 1'b0;
            pend.delete();
            pend.push_back(2);
            if (!d[1]) pend.push_back(3);
            if (d[0])  pend.push_back(4);
            s = 1;
        end else if (pend.size() > 0) begin
            if (a) begin
                m_icw[pend[0]] = d;
                void'(pend.pop_front());
                if (pend.size() == 0) m_ready = 1'b1;
                s = 6;
            end else s = 5;
        end else if (m_ready) begin
            if (a)          begin m_ocw[1] = d; s = 2; end
            else if (!d[3]) begin m_ocw[2] = d; s = 3; end
            else begin
                m_ocw[3] = d; s = 4;
                if (d[1]) m_rd_sel = {1'b0, d[0]};
            end
        end
    endtask

    task automatic do_write(input bit a, input logic [7:0] d, input bit sel, input bit with_rd, input string tag);
        int n_i1 = 0, n_o1 = 0, n_o2 = 0, n_o3 = 0, n_err = 0, n_rs = 0, n_en = 0;
        int low = $urandom_range(2, 4);
        int s = 0;
        bus.a0 = a; bus.din = d; bus.cs_n = !sel;
        bus.wr_n = 1'b0;
        if (with_rd) bus.rd_n = 1'b0;
        for (int i = 0; i < low + 6; i++) begin
            if (i == low) begin bus.wr_n = 1'b1; bus.rd_n = 1'b1; end
            @(negedge clk);
            if (icw1_wr) begin n_i1++; cyc_icw1 = cyc; end
            if (ocw1_wr) n_o1++;
            if (ocw2_wr) n_o2++;
            if (ocw3_wr) n_o3++;
            if (init_error) n_err++;
            if (rd_strobe) n_rs++;
            if (rd_en) n_en++;
            @(posedge clk); #1;
        end
        bus.cs_n = 1'b1;
        if (sel) model_write(a, d, s);
        checks += 18;
        if (n_i1 !== int'(s == 1)) begin errors++; $display("FAIL %s icw1_wr pulses got %0d want %0d", tag, n_i1, int'(s == 1)); end
        if (n_o1 !== int'(s == 2)) begin errors++; $display("FAIL %s ocw1_wr pulses got %0d want %0d", tag, n_o1, int'(s == 2)); end
        if (n_o2 !== int'(s == 3)) begin errors++; $display("FAIL %s ocw2_wr pulses got %0d want %0d", tag, n_o2, int'(s == 3)); end
        if (n_o3 !== int'(s == 4)) begin errors++; $display("FAIL %s ocw3_wr pulses got %0d want %0d", tag, n_o3, int'(s == 4)); end
        if (n_err !== int'(s == 5)) begin errors++; $display("FAIL %s init_error pulses got %0d want %0d", tag, n_err, int'(s == 5)); end
        if (n_rs !== 0) begin errors++; $display("FAIL %s rd_strobe pulses got %0d want 0", tag, n_rs); end
        if (n_en !== 0) begin errors++; $display("FAIL %s rd_en cycles got %0d want 0", tag, n_en); end
        if (icw1 !== m_icw[1]) begin errors++; $display("FAIL %s icw1 got %h want %h", tag, icw1, m_icw[1]); end
        if (icw2 !== m_icw[2]) begin errors++; $display("FAIL %s icw2 got %h want %h", tag, icw2, m_icw[2]); end
        if (icw3 !== m_icw[3]) begin errors++; $display("FAIL %s icw3 got %h want %h", tag, icw3, m_icw[3]); end
        if (icw4 !== m_icw[4]) begin errors++; $display("FAIL %s icw4 got %h want %h", tag, icw4, m_icw[4]); end
        if (ocw1 !== m_ocw[1]) begin errors++; $display("FAIL %s ocw1 got %h want %h", tag, ocw1, m_ocw[1]); end
        if (ocw2 !== m_ocw[2]) begin errors++; $display("FAIL %s ocw2 got %h want %h", tag, ocw2, m_ocw[2]); end
        if (ocw3 !== m_ocw[3]) begin errors++; $display("FAIL %s ocw3 got %h want %h", tag, ocw3, m_ocw[3]); end
        if (int'(icw_state) !== m_state()) begin errors++; $display("FAIL %s icw_state got %0d want %0d", tag, icw_state, m_state()); end
        if (init_done !== (m_state() == 4)) begin errors++; $display("FAIL %s init_done got %b want %b", tag, init_done, m_state() == 4); end
        if (rd_sel !== m_rd_sel) begin errors++; $display("FAIL %s rd_sel got %b want %b", tag, rd_sel, m_rd_sel); end
        if (rd_en !== 1'b0) begin errors++; $display("FAIL %s rd_en idle got %b want 0", tag, rd_en); end
    endtask

    task automatic do_read(input bit a, input string tag);
        int hold = $urandom_range(3, 5);
        int n_rs = 0, n_en = 0, n_bad = 0;
        logic [1:0] want = a ? 2'b10 : m_rd_sel;
        logic [1:0] seen = 2'b00;
        bus.a0 = a; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
        for (int i = 0; i < hold + 5; i++) begin
            if (i == hold) bus.rd_n = 1'b1;
            @(negedge clk);
            if (rd_strobe) n_rs++;
            if (rd_en) begin
                n_en++;
                if (rd_sel !== want) begin n_bad++; seen = rd_sel; end
            end
            @(posedge clk); #1;
        end
        bus.cs_n = 1'b1;
        @(negedge clk);
        checks += 4;
        if (n_rs !== 1) begin errors++; $display("FAIL %s rd_strobe pulses got %0d want 1", tag, n_rs); end
        if (n_en !== hold) begin errors++; $display("FAIL %s rd_en cycles got %0d want %0d", tag, n_en, hold); end
        if (n_bad !== 0) begin errors++; $display("FAIL %s rd_sel during read got %b want %b", tag, seen, want); end
        if (rd_sel !== m_rd_sel) begin errors++; $display("FAIL %s rd_sel after read got %b want %b", tag, rd_sel, m_rd_sel); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if ({icw1, icw2, icw3, icw4} !== 32'h0) begin errors++; $display("FAIL reset icw got %h want 0", {icw1, icw2, icw3, icw4}); end
        if ({ocw1, ocw2, ocw3} !== 24'h0) begin errors++; $display("FAIL reset ocw got %h want 0", {ocw1, ocw2, ocw3}); end
        if (icw_state !== 3'd0) begin errors++; $display("FAIL reset icw_state got %0d want 0", icw_state); end
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset init_done got %b want 0", init_done); end
        if ({icw1_wr, ocw1_wr, ocw2_wr, ocw3_wr, init_error, rd_strobe, rd_en} !== 7'b0) begin
            errors++; $display("FAIL reset strobes got %b want 0", {icw1_wr, ocw1_wr, ocw2_wr, ocw3_wr, init_error, rd_strobe, rd_en});
        end
        if (rd_sel !== 2'b00) begin errors++; $display("FAIL reset rd_sel got %b want 00", rd_sel); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_init_no_icw3();
        do_write(0, 8'h13, 1, 0, "init_a_icw1");
        do_write(1, 8'h20, 1, 0, "init_a_icw2");
        do_write(1, 8'h01, 1, 0, "init_a_icw4");
    endtask

    task automatic test_init_with_icw3();
        do_write(0, 8'h11, 1, 0, "init_b_icw1");
        do_write(1, 8'h08, 1, 0, "init_b_icw2");
        do_write(1, 8'h04, 1, 0, "init_b_icw3");
        do_write(1, 8'h1D, 1, 0, "init_b_icw4");
        do_write(1, 8'hFB, 1, 0, "ocw1_fb");
    endtask

    task automatic test_read_select();
        do_write(0, 8'h0B, 1, 0, "ocw3_rr_isr");
        do_read(0, "read_a0_0");
        do_read(1, "read_a0_1");
        do_write(0, 8'h08, 1, 0, "ocw3_rr0");
        do_read(0, "read_hold");
    endtask

    task automatic test_reinit();
        do_write(1, 8'hFF, 1, 0, "ocw1_ff");
        do_write(0, 8'h17, 1, 0, "reinit_icw1");
        do_write(0, 8'h20, 1, 0, "w2_illegal");
        repeat (25) @(posedge clk);
        #1;
        model_timeout();
        @(negedge clk);
        checks++;
        if (icw_state !== 3'd0) begin errors++; $display("FAIL reinit_timeout icw_state got %0d want 0", icw_state); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int delta = -1;
        do_write(0, 8'h11, 1, 0, "tmo_icw1");
        for (int i = 0; i < 40 && delta < 0; i++) begin
            @(negedge clk);
            if (init_error) delta = cyc - cyc_icw1;
        end
        model_timeout();
        checks += 2;
        if (delta < TMO || delta > TMO + 1) begin errors++; $display("FAIL timeout delay got %0d want %0d..%0d", delta, TMO, TMO + 1); end
        if (icw_state !== 3'd0) begin errors++; $display("FAIL timeout icw_state got %0d want 0", icw_state); end
        @(posedge clk); #1;
        do_write(1, 8'h55, 1, 0, "tmo_ignored");
    endtask

    task automatic test_cs_and_overlap();
        do_write(0, 8'h13, 1, 0, "cs_icw1");
        do_write(1, 8'h20, 1, 0, "cs_icw2");
        do_write(1, 8'h01, 1, 0, "cs_icw4");
        do_write(1, 8'hAA, 0, 0, "cs_high");
        do_write(1, 8'h5A, 1, 1, "wr_rd_overlap");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d = 8'($urandom);
            bit a;
            if (m_state() >= 1 && m_state() <= 3) begin
                if ($urandom_range(0, 9) < 3) begin a = 0; d[4] = 1'b1; end
                else a = 1;
            end else if ($urandom_range(0, 9) < 2) begin
                a = 0; d[4] = 1'b1;
            end else begin
                a = 1'($urandom);
            end
            do_write(a, d, 1, 0, "random_wr");
            if (m_state() == 4 && $urandom_range(0, 3) == 0) do_read(1'($urandom), "random_rd");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midop();
        do_write(0, 8'h13, 1, 0, "mid_icw1");
        do_write(1, 8'h20, 1, 0, "mid_icw2");
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (icw1 !== 8'h00) begin errors++; $display("FAIL midreset icw1 got %h want 00", icw1); end
        if (icw_state !== 3'd0) begin errors++; $display("FAIL midreset icw_state got %0d want 0", icw_state); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_write(1, 8'h33, 1, 0, "post_reset_ignored");
    endtask

    initial begin
        bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.a0 = 1'b0; bus.din = '0;
        model_reset();
        test_reset();
        test_init_no_icw3();
        test_init_with_icw3();
        test_read_select();
        test_reinit();
        test_timeout();
        test_cs_and_overlap();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
